// File: rtl/axis_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_fifo
// Purpose  : AXI-Stream FIFO with store-and-forward mode, bad-frame/overflow
//            dropping, and registered occupancy status.
// Revision : 1.0 - initial release
// ============================================================================
module axis_frame_fifo #(
  parameter int DEPTH              = 256,
  parameter int DATA_WIDTH         = 8,
  parameter int USER_WIDTH         = 1,
  parameter int FRAME_FIFO         = 1,
  parameter int DROP_WHEN_FULL     = 0,
  parameter int DROP_BAD_FRAME     = 1,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 4,
  parameter int ALMOST_EMPTY_LEVEL = 4,
  localparam int ADDR_WIDTH        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [ADDR_WIDTH:0]   status_depth,
  output logic [ADDR_WIDTH:0]   status_depth_commit,
  output logic                  status_almost_full,
  output logic                  status_almost_empty,
  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame
);

  localparam int                RW        = USER_WIDTH + 1 + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL  = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_LVL  = (ADDR_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [RW-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] wr_commit_q, wr_commit_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] rd_commit_q, rd_commit_d;

  logic          pipe_valid_q;
  logic [RW-1:0] pipe_word_q;
  logic          m_valid_q;
  logic [RW-1:0] m_word_q;

  logic [ADDR_WIDTH:0] depth_q, depth_commit_q;
  logic                afull_q, aempty_q, ovf_q, bad_q, good_q;

  logic w_full, w_oversize, w_full_drop, w_s_ready, w_s_hs, w_mem_we;
  logic w_ovf, w_bad, w_good;
  logic w_empty, w_out_ready, w_pipe_ready, w_rd_en, w_m_hs;
  logic [ADDR_WIDTH:0] w_depth_d, w_depth_commit_d;

  // Slots held in the read pipeline stay occupied until the reader takes them.
  assign w_full     = ((wr_ptr_q - rd_commit_q) == DEPTH_W);
  assign w_oversize = (wr_commit_q == rd_commit_q);

  always_comb begin
    w_full_drop = 1'b0;
    w_s_ready   = 1'b0;
    if (FRAME_FIFO == 0) begin
      w_s_ready = (DROP_WHEN_FULL != 0) || !w_full;
    end else if (state_q == ST_DROP) begin
      w_s_ready = 1'b1;
    end else begin
      w_full_drop = w_full && ((DROP_WHEN_FULL != 0) ||
                               ((state_q == ST_WRITE) && w_oversize));
      w_s_ready   = !w_full || w_full_drop;
    end
  end

  assign s_axis_tready = w_s_ready && !reset;
  assign w_s_hs        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    w_mem_we    = 1'b0;
    w_ovf       = 1'b0;
    w_bad       = 1'b0;
    w_good      = 1'b0;
    if (FRAME_FIFO == 0) begin
      if (w_s_hs) begin
        if (w_full) begin
          w_ovf = 1'b1;
        end else begin
          w_mem_we    = 1'b1;
          wr_ptr_d    = wr_ptr_q + PTR_ONE;
          wr_commit_d = wr_ptr_q + PTR_ONE;
        end
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_WRITE: begin
          if (w_s_hs) begin
            if (w_full) begin
              // Only reachable when dropping on full; discard the whole frame.
              wr_ptr_d = wr_commit_q;
              w_ovf    = 1'b1;
              state_d  = s_axis_tlast ? ST_IDLE : ST_DROP;
            end else if (s_axis_tlast) begin
              state_d = ST_IDLE;
              if (s_axis_tuser[0] && (DROP_BAD_FRAME != 0)) begin
                wr_ptr_d = wr_commit_q;
                w_bad    = 1'b1;
              end else begin
                w_mem_we    = 1'b1;
                wr_ptr_d    = wr_ptr_q + PTR_ONE;
                wr_commit_d = wr_ptr_q + PTR_ONE;
                w_good      = 1'b1;
              end
            end else begin
              w_mem_we = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_ONE;
              state_d  = ST_WRITE;
            end
          end
        end
        ST_DROP: begin
          if (w_s_hs && s_axis_tlast) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign w_empty      = (wr_commit_q == rd_ptr_q);
  assign w_out_ready  = !m_valid_q || m_axis_tready;
  assign w_pipe_ready = !pipe_valid_q || w_out_ready;
  assign w_rd_en      = w_pipe_ready && !w_empty;
  assign w_m_hs       = m_valid_q && m_axis_tready;
  assign rd_ptr_d     = w_rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  assign rd_commit_d  = w_m_hs ? (rd_commit_q + PTR_ONE) : rd_commit_q;

  assign w_depth_d        = wr_ptr_d - rd_commit_d;
  assign w_depth_commit_d = wr_commit_d - rd_commit_d;

  // RAM array and its read register carry no reset so they map to block RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    if (w_rd_en)  pipe_word_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      wr_commit_q    <= '0;
      rd_ptr_q       <= '0;
      rd_commit_q    <= '0;
      pipe_valid_q   <= 1'b0;
      m_valid_q      <= 1'b0;
      m_word_q       <= '0;
      depth_q        <= '0;
      depth_commit_q <= '0;
      afull_q        <= 1'b0;
      aempty_q       <= 1'b1;
      ovf_q          <= 1'b0;
      bad_q          <= 1'b0;
      good_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_commit_q <= rd_commit_d;
      if (w_pipe_ready) pipe_valid_q <= !w_empty;
      if (w_out_ready) begin
        m_valid_q <= pipe_valid_q;
        if (pipe_valid_q) m_word_q <= pipe_word_q;
      end
      depth_q        <= w_depth_d;
      depth_commit_q <= w_depth_commit_d;
      afull_q        <= (w_depth_d >= AF_LVL);
      aempty_q       <= (w_depth_commit_d <= AE_LVL);
      ovf_q          <= w_ovf;
      bad_q          <= w_bad;
      good_q         <= w_good;
    end
  end

  assign m_axis_tvalid       = m_valid_q;
  assign m_axis_tdata        = m_word_q[DATA_WIDTH-1:0];
  assign m_axis_tlast        = m_word_q[DATA_WIDTH];
  assign m_axis_tuser        = m_word_q[RW-1:DATA_WIDTH+1];
  assign status_depth        = depth_q;
  assign status_depth_commit = depth_commit_q;
  assign status_almost_full  = afull_q;
  assign status_almost_empty = aempty_q;
  assign status_overflow     = ovf_q;
  assign status_bad_frame    = bad_q;
  assign status_good_frame   = good_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_frame_fifo
// Purpose  : Self-checking bench for axis_frame_fifo in three configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_frame_fifo;

  localparam int N = 3;  // 0: cut-through, 1: frame mode, 2: cut-through drop-on-full

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     [N];
  logic [7:0] s_data  [N];
  logic       s_valid [N];
  logic       s_ready [N];
  logic       s_last  [N];
  logic [0:0] s_user  [N];
  logic [7:0] m_data  [N];
  logic       m_valid [N];
  logic       m_ready [N];
  logic       m_last  [N];
  logic [0:0] m_user  [N];
  logic [4:0] depth   [N];
  logic [4:0] depth_c [N];
  logic       afull   [N];
  logic       aempty  [N];
  logic       ovf     [N];
  logic       bad     [N];
  logic       good    [N];

  axis_frame_fifo #(.DEPTH(16), .FRAME_FIFO(0), .DROP_WHEN_FULL(0)) u_ct (
    .clk(clk), .reset(rst[0]),
    .s_axis_tdata(s_data[0]), .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]),
    .s_axis_tlast(s_last[0]), .s_axis_tuser(s_user[0]),
    .m_axis_tdata(m_data[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]),
    .m_axis_tlast(m_last[0]), .m_axis_tuser(m_user[0]),
    .status_depth(depth[0]), .status_depth_commit(depth_c[0]),
    .status_almost_full(afull[0]), .status_almost_empty(aempty[0]),
    .status_overflow(ovf[0]), .status_bad_frame(bad[0]), .status_good_frame(good[0]));

  axis_frame_fifo #(.DEPTH(16), .FRAME_FIFO(1), .DROP_WHEN_FULL(0), .DROP_BAD_FRAME(1)) u_fr (
    .clk(clk), .reset(rst[1]),
    .s_axis_tdata(s_data[1]), .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]),
    .s_axis_tlast(s_last[1]), .s_axis_tuser(s_user[1]),
    .m_axis_tdata(m_data[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]),
    .m_axis_tlast(m_last[1]), .m_axis_tuser(m_user[1]),
    .status_depth(depth[1]), .status_depth_commit(depth_c[1]),
    .status_almost_full(afull[1]), .status_almost_empty(aempty[1]),
    .status_overflow(ovf[1]), .status_bad_frame(bad[1]), .status_good_frame(good[1]));

  axis_frame_fifo #(.DEPTH(16), .FRAME_FIFO(0), .DROP_WHEN_FULL(1)) u_ctd (
    .clk(clk), .reset(rst[2]),
    .s_axis_tdata(s_data[2]), .s_axis_tvalid(s_valid[2]), .s_axis_tready(s_ready[2]),
    .s_axis_tlast(s_last[2]), .s_axis_tuser(s_user[2]),
    .m_axis_tdata(m_data[2]), .m_axis_tvalid(m_valid[2]), .m_axis_tready(m_ready[2]),
    .m_axis_tlast(m_last[2]), .m_axis_tuser(m_user[2]),
    .status_depth(depth[2]), .status_depth_commit(depth_c[2]),
    .status_almost_full(afull[2]), .status_almost_empty(aempty[2]),
    .status_overflow(ovf[2]), .status_bad_frame(bad[2]), .status_good_frame(good[2]));

  int checks   = 0;
  int failures = 0;
  int ovf_cnt  [N] = '{default: 0};
  int bad_cnt  [N] = '{default: 0};
  int good_cnt [N] = '{default: 0};

  // Scoreboard entry: {dut index, tuser, tlast, tdata}
  logic [11:0] sbq [$];
  logic [11:0] mon_act, mon_exp;

  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (ovf[d] === 1'b1)  ovf_cnt[d]++;
      if (bad[d] === 1'b1)  bad_cnt[d]++;
      if (good[d] === 1'b1) good_cnt[d]++;
      if (m_valid[d] === 1'b1 && m_ready[d] === 1'b1) begin
        mon_act = {2'(d), m_user[d], m_last[d], m_data[d]};
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected dut=%0d actual=0x%0h required=no_beat", d, mon_act);
        end else begin
          mon_exp = sbq.pop_front();
          if (mon_act !== mon_exp) begin
            failures++;
            $display("FAIL out_beat dut=%0d actual=0x%0h required=0x%0h", d, mon_act, mon_exp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One beat; waits for tready (bounded), handshake on the following posedge.
  task automatic send(input int d, input logic [7:0] data, input logic last,
                      input logic user, input bit expect_out, output int waits);
    s_data[d]  = data;
    s_last[d]  = last;
    s_user[d]  = user;
    s_valid[d] = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (s_ready[d] === 1'b1) break;
      waits++;
      if (waits > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout dut=%0d actual=no_ready required=ready", d);
        break;
      end
    end
    if (expect_out && waits <= 200) sbq.push_back({2'(d), user, last, data});
    @(posedge clk);
    #1;
    s_valid[d] = 1'b0;
    s_last[d]  = 1'b0;
    s_user[d]  = 1'b0;
  endtask

  task automatic send_frame(input int d, input logic [7:0] base, input int n,
                            input logic bad_last, input bit expect_out, output int total_waits);
    int w;
    total_waits = 0;
    for (int i = 0; i < n; i++) begin
      send(d, base + 8'(i), (i == n - 1), (i == n - 1) && bad_last, expect_out, w);
      total_waits += w;
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (sbq.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, sbq.size(), 0);
    sbq.delete();
    idle(2);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       mready;
    logic       exp_ready;
    logic [4:0] exp_depth;
    logic       exp_af;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [17];
    int   w, g0, b0, o0;

    for (int i = 0; i < 17; i++) begin
      vecs[i].data      = (i < 16) ? 8'(i) : 8'hEE;
      vecs[i].valid     = 1'b1;
      vecs[i].mready    = 1'b0;
      vecs[i].exp_ready = (i < 16);
      vecs[i].exp_depth = 5'(i);
      vecs[i].exp_af    = (i >= 12);
    end

    for (int d = 0; d < N; d++) begin
      rst[d] = 1'b1; s_valid[d] = 1'b0; s_data[d] = '0;
      s_last[d] = 1'b0; s_user[d] = '0; m_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready_ct", s_ready[0], 0);
    chk("rst_s_tready_ctd", s_ready[2], 0);
    @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) rst[d] = 1'b0;
    @(negedge clk);
    chk("rst_s_tready_after", s_ready[0], 1);
    chk("rst_m_tvalid", m_valid[0], 0);
    chk("rst_m_word", {m_user[0], m_last[0], m_data[0]}, 0);
    chk("rst_depth", depth[0], 0);
    chk("rst_depth_commit", depth_c[0], 0);
    chk("rst_almost_empty", aempty[0], 1);
    chk("rst_almost_full", afull[0], 0);
    chk("rst_pulses", {ovf[1], bad[1], good[1]}, 0);
    idle(1);

    // Cut-through fill to full with the reader stalled.
    for (int i = 0; i < 17; i++) begin
      s_data[0]  = vecs[i].data;
      s_valid[0] = vecs[i].valid;
      s_last[0]  = 1'b0;
      m_ready[0] = vecs[i].mready;
      @(negedge clk);
      chk("ct_s_tready", s_ready[0], vecs[i].exp_ready);
      chk("ct_depth", depth[0], vecs[i].exp_depth);
      chk("ct_almost_full", afull[0], vecs[i].exp_af);
      if (vecs[i].valid && vecs[i].exp_ready) sbq.push_back({2'd0, 1'b0, 1'b0, vecs[i].data});
      @(posedge clk);
      #1;
    end
    s_valid[0] = 1'b0;
    m_ready[0] = 1'b1;
    wait_drain("ct_drain", 100);
    @(negedge clk);
    chk("ct_depth_empty", depth[0], 0);
    chk("ct_depth_commit_empty", depth_c[0], 0);
    chk("ct_almost_empty_end", aempty[0], 1);
    idle(1);

    // Cut-through latency: tvalid rises two cycles after the handshake edge.
    send(0, 8'h55, 1'b1, 1'b0, 1'b1, w);
    @(negedge clk); chk("ct_lat_c0", m_valid[0], 0);
    @(negedge clk); chk("ct_lat_c1", m_valid[0], 0);
    @(negedge clk); chk("ct_lat_c2", m_valid[0], 1);
    wait_drain("ct_lat_drain", 20);

    // Frame mode: output held back until the tlast handshake.
    m_ready[1] = 1'b1;
    g0 = good_cnt[1];
    for (int i = 0; i < 5; i++) begin
      send(1, 8'hA0 + 8'(i), (i == 4), 1'b0, 1'b1, w);
      chk("fr_hold", m_valid[1], 0);
    end
    @(negedge clk); chk("fr_lat_c0", m_valid[1], 0);
    @(negedge clk); chk("fr_lat_c1", m_valid[1], 0);
    @(negedge clk); chk("fr_lat_c2", m_valid[1], 1);
    wait_drain("fr_drain", 40);
    chk("fr_good_pulse", good_cnt[1] - g0, 1);

    // Bad frame dropped, following good frame delivered.
    g0 = good_cnt[1];
    b0 = bad_cnt[1];
    send_frame(1, 8'hB0, 4, 1'b1, 1'b0, w);
    send_frame(1, 8'hC0, 3, 1'b0, 1'b1, w);
    wait_drain("bad_drain", 40);
    chk("bad_pulse", bad_cnt[1] - b0, 1);
    chk("bad_good_pulse", good_cnt[1] - g0, 1);

    // Oversize frame: accepted in full, dropped, FIFO usable afterwards.
    o0 = ovf_cnt[1];
    send_frame(1, 8'hD0, 20, 1'b0, 1'b0, w);
    chk("ov_all_accepted_waits", w, 0);
    idle(3);
    chk("ov_overflow_pulse", ovf_cnt[1] - o0, 1);
    chk("ov_depth_rewound", depth[1], 0);
    chk("ov_no_output", m_valid[1], 0);
    send_frame(1, 8'hE0, 2, 1'b0, 1'b1, w);
    wait_drain("ov_next_drain", 40);

    // Drop-on-full cut-through: excess beats discarded, contents unchanged.
    m_ready[2] = 1'b0;
    send_frame(2, 8'h30, 16, 1'b0, 1'b1, w);
    idle(1);
    chk("ctd_depth_full", depth[2], 16);
    o0 = ovf_cnt[2];
    for (int i = 0; i < 3; i++) begin
      send(2, 8'h70 + 8'(i), 1'b0, 1'b0, 1'b0, w);
      chk("ctd_ready_when_full", w, 0);
    end
    idle(2);
    chk("ctd_overflow_pulses", ovf_cnt[2] - o0, 3);
    chk("ctd_depth_kept", depth[2], 16);
    m_ready[2] = 1'b1;
    wait_drain("ctd_drain", 100);
    chk("ctd_depth_end", depth[2], 0);

    // Reset in the middle of a partial frame.
    g0 = good_cnt[1];
    b0 = bad_cnt[1];
    o0 = ovf_cnt[1];
    for (int i = 0; i < 6; i++) send(1, 8'hF0 + 8'(i), 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    chk("mr_depth_before", depth[1], 6);
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    @(negedge clk);
    chk("mr_s_tready_in_reset", s_ready[1], 0);
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("mr_depth_after", depth[1], 0);
    chk("mr_m_tvalid_after", m_valid[1], 0);
    chk("mr_depth_commit_after", depth_c[1], 0);
    idle(1);
    send_frame(1, 8'h11, 2, 1'b0, 1'b1, w);
    wait_drain("mr_next_drain", 40);
    chk("mr_no_bad_pulse", bad_cnt[1] - b0, 0);
    chk("mr_no_ovf_pulse", ovf_cnt[1] - o0, 0);
    chk("mr_good_pulse", good_cnt[1] - g0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
